// File: rtl/cam_capture_ycbcr.sv
// cam_capture_ycbcr
// Capture front end for an OV7670-style sensor, running entirely in the PCLK
// domain. It assembles YCbCr 4:2:2 byte quads (Cb, Y0, Cr, Y1) into pixel
// pairs. It applies 1/2/4 decimation and optional green chroma keying, and
// emits linear framebuffer writes.
//
// Ports:
//   PCLK        pixel clock (only clock)
//   reset_n     synchronous active-low reset
//   VSYNC       high during vertical blanking; falling edge starts a frame
//   HREF        high while active line bytes are on D
//   D           sensor byte
//   enable      capture arm, sampled only while idle
//   scale       0: 1:1, 1: /2, 2 or 3: /4 (latched at frame start)
//   mode        0: luma, 1: green key (latched at frame start)
//   wr_en       framebuffer write strobe
//   wr_addr     linear write address
//   wr_data     pixel value
//   busy        high from frame start until frame end
//   frame_done  one-cycle pulse per completed frame
//   ovf         sticky overflow (pixel or line beyond active area)
//
// Handshake: wr_en is a one-way strobe with no back-pressure. Each cycle
// with wr_en=1 is exactly one write of wr_data to wr_addr, and the
// framebuffer must accept it. wr_addr/wr_data are don't-care while wr_en=0.
module cam_capture_ycbcr #(
  parameter int               H_ACTIVE = 640,
  parameter int               V_ACTIVE = 480,
  parameter int               DATA_W   = 8,
  parameter int               ADDR_W   = 19,
  parameter logic [DATA_W-1:0] CB_MAX  = 8'd115,
  parameter logic [DATA_W-1:0] CR_MAX  = 8'd115,
  parameter logic [DATA_W-1:0] KEY_VAL = 8'hFF
) (
  input  logic              PCLK,
  input  logic              reset_n,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic [DATA_W-1:0] D,
  input  logic              enable,
  input  logic [1:0]        scale,
  input  logic              mode,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              ovf
);

  localparam int CW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_LINE_WAIT, S_CAPTURE, S_FRAME_END
  } state_t;

  state_t state, state_next;

  logic              vsync_q;
  logic              vs_fall, vs_rise;
  logic [1:0]        phase;
  logic [CW-1:0]     xcnt, row;
  logic [1:0]        s_lat;
  logic              mode_lat;
  logic [ADDR_W-1:0] row_base;
  logic [DATA_W-1:0] cb, cr, y0;
  logic              y1_pend, y1_keep;
  logic [ADDR_W-1:0] y1_addr;
  logic [DATA_W-1:0] y1_data;

  logic [CW-1:0]     mask, x1;
  logic              row_ok, keep0, keep1, key;
  logic [ADDR_W-1:0] addr0, addr1, line_step;

  assign vs_fall = vsync_q & ~VSYNC;
  assign vs_rise = ~vsync_q & VSYNC;

  // xcnt always holds the even x of the current pair, so x1 is just bit 0 set.
  assign x1        = xcnt | CW'(1);
  assign mask      = (CW'(1) << s_lat) - CW'(1);
  assign row_ok    = ((row & mask) == '0) && (row < CW'(V_ACTIVE));
  assign keep0     = row_ok && ((xcnt & mask) == '0) && (xcnt < CW'(H_ACTIVE));
  assign keep1     = row_ok && ((x1 & mask) == '0) && (x1 < CW'(H_ACTIVE));
  assign addr0     = row_base + ADDR_W'(xcnt >> s_lat);
  assign addr1     = row_base + ADDR_W'(x1 >> s_lat);
  assign line_step = ADDR_W'(H_ACTIVE) >> s_lat;
  // Cb and Cr were captured earlier in the quad; one decision covers both pixels.
  assign key       = mode_lat && (cb < CB_MAX) && (cr < CR_MAX);

  always_ff @(posedge PCLK) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (enable) state_next = S_ARMED;
      S_ARMED:     if (vs_fall) state_next = S_LINE_WAIT;
      S_LINE_WAIT: if (vs_rise) state_next = S_FRAME_END;
                   else if (HREF) state_next = S_CAPTURE;
      S_CAPTURE:   if (vs_rise) state_next = S_FRAME_END;
                   else if (!HREF) state_next = S_LINE_WAIT;
      S_FRAME_END: state_next = enable ? S_ARMED : S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!reset_n) begin
      vsync_q    <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      ovf        <= 1'b0;
      phase      <= '0;
      xcnt       <= '0;
      row        <= '0;
      row_base   <= '0;
      s_lat      <= '0;
      mode_lat   <= 1'b0;
      cb         <= '0;
      cr         <= '0;
      y0         <= '0;
      y1_pend    <= 1'b0;
      y1_keep    <= 1'b0;
      y1_addr    <= '0;
      y1_data    <= '0;
    end else begin
      vsync_q    <= VSYNC;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;

      // The second pixel of a pair always issues one cycle after the first,
      // whatever HREF/VSYNC do. At a frame end it lands no later than
      // frame_done.
      if (y1_pend) begin
        wr_en   <= y1_keep;
        wr_addr <= y1_addr;
        wr_data <= y1_data;
        y1_pend <= 1'b0;
      end

      case (state)
        S_ARMED: begin
          if (vs_fall) begin
            s_lat    <= (scale == 2'd0) ? 2'd0 : (scale == 2'd1) ? 2'd1 : 2'd2;
            mode_lat <= mode;
            ovf      <= 1'b0;
            row      <= '0;
            row_base <= '0;
            xcnt     <= '0;
            phase    <= '0;
            busy     <= 1'b1;
          end
        end
        S_LINE_WAIT, S_CAPTURE: begin
          if (vs_rise) begin
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else if (HREF) begin
            phase <= phase + 2'd1;
            case (phase)
              2'd0: cb <= D;
              2'd1: y0 <= D;
              2'd2: cr <= D;
              2'd3: begin
                wr_en   <= keep0;
                wr_addr <= addr0;
                wr_data <= key ? KEY_VAL : y0;
                y1_pend <= 1'b1;
                y1_keep <= keep1;
                y1_addr <= addr1;
                y1_data <= key ? KEY_VAL : D;
                if (!(x1 < CW'(H_ACTIVE)) || !(row < CW'(V_ACTIVE))) ovf <= 1'b1;
                if (~&xcnt[CW-1:1]) xcnt <= xcnt + CW'(2);
              end
              default: ;
            endcase
          end else begin
            // HREF low: any partial quad is dropped and the next line restarts.
            phase <= '0;
            xcnt  <= '0;
            if (state == S_CAPTURE) begin
              if (~&row) row <= row + CW'(1);
              if (row_ok) row_base <= row_base + line_step;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture_ycbcr.sv
// Bench for cam_capture_ycbcr with a reduced 8x4 active area.
// Expected writes come from a pixel-level model: each completed Cb/Y0/Cr/Y1
// quad is turned into up to two (cycle, addr, data) entries from the keep,
// key and address rules. A compare process checks every write and every
// frame_done pulse against them. Literal expectations per frame pin the model.
module tb_cam_capture_ycbcr;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int AW = 19;
  localparam int DW = 8;
  localparam int EW = 32 + AW + DW;

  logic          PCLK = 1'b0;
  logic          reset_n, VSYNC, HREF, enable, mode;
  logic [DW-1:0] D;
  logic [1:0]    scale;
  logic          wr_en, busy, frame_done, ovf;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  cam_capture_ycbcr #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(DW), .ADDR_W(AW)) dut (
    .PCLK(PCLK), .reset_n(reset_n), .VSYNC(VSYNC), .HREF(HREF), .D(D),
    .enable(enable), .scale(scale), .mode(mode), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .frame_done(frame_done), .ovf(ovf)
  );

  // clock / reset infrastructure
  always #5 PCLK = ~PCLK;
  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at time %0t", $time);
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [EW-1:0]    exp_q[$];
  logic [EW-1:0]    e_cur;
  logic [AW+DW-1:0] wlog[$];
  int fd_cyc = -1;
  int fd_exp = 0;
  int fd_seen = 0;

  // model state
  bit   m_in = 1'b0;
  int   m_row = 0;
  int   m_s = 0;
  bit   m_mode = 1'b0;
  bit   exp_ovf = 1'b0;
  logic [7:0] lb[32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // compare process
  always @(negedge PCLK) begin
    while (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_write: cycle %0d, expected addr %0h data %0h",
               int'(exp_q[0][EW-1 -: 32]), exp_q[0][AW+DW-1:DW], exp_q[0][DW-1:0]);
      void'(exp_q.pop_front());
    end
    if (wr_en === 1'b1) begin
      wlog.push_back({wr_addr, wr_data});
      checks++;
      if (exp_q.size() == 0 || int'(exp_q[0][EW-1 -: 32]) != cyc) begin
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h at cycle %0d, none expected",
                 wr_addr, wr_data, cyc);
      end else begin
        e_cur = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e_cur[AW+DW-1:0]) begin
          errors++;
          $display("FAIL write_value: got addr %0h data %0h expected addr %0h data %0h",
                   wr_addr, wr_data, e_cur[AW+DW-1:DW], e_cur[DW-1:0]);
        end
      end
    end else if (wr_en !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL wr_en_known: got %b expected 0 or 1", wr_en);
    end
    if (frame_done === 1'b1) begin
      fd_seen++;
      checks++;
      if (cyc != fd_cyc || busy !== 1'b0) begin
        errors++;
        $display("FAIL frame_done_timing: at cycle %0d busy %b, expected cycle %0d busy 0",
                 cyc, busy, fd_cyc);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge PCLK);
  endtask

  // Quad ending at byte i has just been driven; its writes are expected
  // one and two cycles after the Y1 byte is sampled.
  task automatic push_pair(input int i);
    int p, x, a;
    bit k;
    logic [7:0] v;
    p = 1 << m_s;
    k = m_mode && (lb[i-3] < 8'd115) && (lb[i-1] < 8'd115);
    for (int j = 0; j < 2; j++) begin
      x = (i / 4) * 2 + j;
      v = k ? 8'hFF : ((j == 0) ? lb[i-2] : lb[i]);
      if (x >= H || m_row >= V) exp_ovf = 1'b1;
      if ((x % p) == 0 && (m_row % p) == 0 && x < H && m_row < V) begin
        a = ((m_row + p - 1) / p) * (H / p) + x / p;
        exp_q.push_back({32'(cyc + 1 + j), AW'(a), v});
      end
    end
  endtask

  task automatic send_line(input int n, input bit close);
    for (int i = 0; i < n; i++) begin
      tick();
      HREF = 1'b1;
      D = lb[i];
      if (m_in && (i % 4) == 3) push_pair(i);
    end
    if (close) begin
      tick();
      HREF = 1'b0;
      if (m_in) m_row++;
      tick();
      tick();
    end
  endtask

  task automatic frame_start(input int sc, input bit md, input bit active);
    tick();
    VSYNC = 1'b1;
    scale = 2'(sc);
    mode = md;
    tick();
    tick();
    VSYNC = 1'b0;
    if (active) begin
      m_in = 1'b1;
      m_row = 0;
      m_s = (sc == 0) ? 0 : (sc == 1) ? 1 : 2;
      m_mode = md;
      exp_ovf = 1'b0;
    end
    tick();
    // Changing scale/mode after the frame start must have no effect.
    scale = 2'(sc + 1);
    mode = ~md;
    tick();
  endtask

  task automatic frame_end();
    tick();
    VSYNC = 1'b1;
    if (m_in) begin
      fd_cyc = cyc + 1;
      fd_exp++;
      m_in = 1'b0;
    end
    tick();
    tick();
    tick();
  endtask

  task automatic fill_y(input int base);
    for (int p = 0; p < 8; p++) begin
      lb[4*p]   = 8'd80;
      lb[4*p+1] = 8'(base + 2*p);
      lb[4*p+2] = 8'd80;
      lb[4*p+3] = 8'(base + 2*p + 1);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    reset_n = 1'b0; VSYNC = 1'b0; HREF = 1'b0; D = '0;
    enable = 1'b0; scale = 2'd0; mode = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset_n = 1'b1;
    enable = 1'b1;
    tick();

    // 1:1 luma, two full lines
    wlog.delete();
    frame_start(0, 1'b0, 1'b1);
    check("a_busy_in_frame", busy, 1);
    for (int r = 0; r < 2; r++) begin
      fill_y(10 + 8*r);
      send_line(16, 1'b1);
    end
    frame_end();
    check("a_busy_after", busy, 0);
    check("a_count", wlog.size(), 16);
    check("a_w0", wlog[0], {19'd0, 8'd10});
    check("a_w7", wlog[7], {19'd7, 8'd17});
    check("a_w8", wlog[8], {19'd8, 8'd18});
    check("a_w15", wlog[15], {19'd15, 8'd25});

    // /2 decimation, four lines: rows 0 and 2, even x only
    wlog.delete();
    frame_start(1, 1'b0, 1'b1);
    for (int r = 0; r < 4; r++) begin
      fill_y(10 + 8*r);
      send_line(16, 1'b1);
    end
    frame_end();
    check("b_count", wlog.size(), 8);
    check("b_w1", wlog[1], {19'd1, 8'd12});
    check("b_w4", wlog[4], {19'd4, 8'd26});
    check("b_w7", wlog[7], {19'd7, 8'd32});

    // green key, including the strict-less-than boundary at 115
    wlog.delete();
    lb[0] = 8'd100; lb[1] = 8'd50; lb[2] = 8'd100; lb[3] = 8'd60;
    lb[4] = 8'd130; lb[5] = 8'd50; lb[6] = 8'd100; lb[7] = 8'd60;
    lb[8] = 8'd114; lb[9] = 8'd1;  lb[10] = 8'd114; lb[11] = 8'd2;
    lb[12] = 8'd115; lb[13] = 8'd3; lb[14] = 8'd100; lb[15] = 8'd4;
    frame_start(0, 1'b1, 1'b1);
    send_line(16, 1'b1);
    frame_end();
    check("c_count", wlog.size(), 8);
    check("c_w0", wlog[0], {19'd0, 8'hFF});
    check("c_w1", wlog[1], {19'd1, 8'hFF});
    check("c_w2", wlog[2], {19'd2, 8'd50});
    check("c_w3", wlog[3], {19'd3, 8'd60});
    check("c_w5", wlog[5], {19'd5, 8'hFF});
    check("c_w6", wlog[6], {19'd6, 8'd3});

    // overlong line (10 px) then a line ending at phase 1
    wlog.delete();
    frame_start(0, 1'b0, 1'b1);
    fill_y(10);
    send_line(20, 1'b1);
    fill_y(50);
    send_line(6, 1'b1);
    frame_end();
    check("d_count", wlog.size(), 10);
    check("d_w7", wlog[7], {19'd7, 8'd17});
    check("d_w8", wlog[8], {19'd8, 8'd50});
    check("d_w9", wlog[9], {19'd9, 8'd51});
    check("d_ovf_model", exp_ovf, 1);
    check("d_ovf", ovf, 1);
    repeat (4) tick();
    check("d_ovf_held", ovf, 1);

    // reset in the middle of a line, right as a pair is being written
    frame_start(0, 1'b0, 1'b1);
    check("f_ovf_cleared", ovf, 0);
    check("f_busy", busy, 1);
    fill_y(10);
    send_line(9, 1'b0);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    m_in = 1'b0;
    tick();
    check_idle_outputs("midreset");
    reset_n = 1'b1;
    wlog.delete();
    tick();
    HREF = 1'b0;
    send_line(16, 1'b1);
    frame_end();
    check("f_no_write_after_reset", wlog.size(), 0);
    check("f_busy_after_reset", busy, 0);

    // recovery frame, scale=3 behaves as /4
    frame_start(3, 1'b0, 1'b1);
    for (int r = 0; r < 4; r++) begin
      fill_y(10 + 8*r);
      send_line(16, 1'b1);
    end
    frame_end();
    check("g_count", wlog.size(), 2);
    check("g_w0", wlog[0], {19'd0, 8'd10});
    check("g_w1", wlog[1], {19'd1, 8'd14});

    // enable dropped mid-frame: frame completes, then capture stays off
    wlog.delete();
    frame_start(0, 1'b0, 1'b1);
    fill_y(10);
    send_line(16, 1'b1);
    enable = 1'b0;
    fill_y(18);
    send_line(16, 1'b1);
    frame_end();
    check("e_count", wlog.size(), 16);
    check("e_busy", busy, 0);
    frame_start(0, 1'b0, 1'b0);
    check("e_busy_disabled", busy, 0);
    send_line(16, 1'b1);
    frame_end();
    check("e_no_more_writes", wlog.size(), 16);
    check("e_busy_end", busy, 0);

    repeat (3) tick();
    check("frame_done_count", fd_seen, fd_exp);
    check("exp_queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cam_capture_ycbcr.md
Name: cam_capture_ycbcr

Overview:
Next-generation camera capture front end for the OV7670-style sensor path, running in the PCLK domain ahead of the framebuffer. It takes the byte stream (D, VSYNC, HREF) and assembles YCbCr 4:2:2 pixel pairs. It supports runtime decimation (1, 2 or 4) and an optional green chroma-key mode, and issues framebuffer writes as linear addresses with frame/line bookkeeping. It replaces the fixed 640x480 luma-only capture plus external green detection and Y_2 interleave.

Parameters:
H_ACTIVE, 640, active pixels per line at full scale
V_ACTIVE, 480, active lines per frame at full scale
DATA_W, 8, sensor byte and pixel width
ADDR_W, 19, framebuffer address width
CB_MAX, 8'd115, green key: Cb strictly below this
CR_MAX, 8'd115, green key: Cr strictly below this
KEY_VAL, 8'hFF, pixel value written for keyed (green) pixels in mode 1

Ports:
PCLK  in  1  pixel clock; the only clock
reset_n  in  1  synchronous active-low reset
VSYNC  in  1  high = vertical blanking
HREF  in  1  high = active line bytes on D
D  in  DATA_W  sensor byte
enable  in  1  capture arm; sampled only in IDLE
scale  in  2  0: 1:1, 1: /2, 2: /4, 3: treated as /4; latched at frame start
mode  in  1  0: luma, 1: green key; latched at frame start
wr_en  out  1  framebuffer write strobe
wr_addr  out  ADDR_W  linear write address
wr_data  out  DATA_W  pixel value
busy  out  1  high from frame start until FRAME_END
frame_done  out  1  one-cycle pulse per completed frame
ovf  out  1  sticky: bytes beyond H_ACTIVE or lines beyond V_ACTIVE seen; cleared at frame start

Behaviour:
- Reset (reset_n=0 at a PCLK edge): state IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, ovf=0; all counters cleared. Reset mid-frame abandons the frame; capture resumes only at the next VSYNC falling edge.
- FSM: IDLE -> ARMED when enable=1. ARMED -> LINE_WAIT on a VSYNC 1->0 edge, which is the frame start: latch scale/mode, clear ovf, row=0, row_base=0, busy=1. LINE_WAIT -> CAPTURE on HREF=1. CAPTURE -> LINE_WAIT on HREF=0, which ends the line: row++, and if the row was kept, row_base += H_ACTIVE>>s. Any state except IDLE/ARMED -> FRAME_END on a VSYNC 0->1 edge. FRAME_END pulses frame_done=1 for 1 cycle and drops busy, then goes to ARMED if enable=1, else IDLE.
- enable=0 mid-frame does not abort; the frame completes first.
- Byte phase: 2-bit counter, reset to 0 at each HREF rise, increments on each HREF=1 byte. Order is Cb, Y0, Cr, Y1.
- Pair valid on the phase-3 byte. Pixel x0 = 2*pair_index, x1 = x0+1.
- Keep rule: pixel kept iff (x mod 2^s)==0, (row mod 2^s)==0, x<H_ACTIVE and row<V_ACTIVE. Here s=0/1/2.
- Value: mode 0 gives Y. Mode 1 gives KEY_VAL if (Cb<CB_MAX && Cr<CR_MAX), else Y. The key decision is shared by both pixels of the pair.
- Writes: Y0 is registered on the edge sampling phase 3 (wr_en=1 the following cycle). Y1 is written on the next cycle regardless of HREF, so at most 2 consecutive writes.
- Latency: 1 PCLK from the Y1 byte to the Y0 write, 2 PCLK to the Y1 write.
- Address: row_base + (x>>s), ADDR_W unsigned, wraps silently at 2^ADDR_W.
- Dropped pixels: no write. x>=H_ACTIVE or row>=V_ACTIVE sets ovf.
- Short lines: accepted. A trailing incomplete pair (HREF falls at phase !=3) is discarded.
- HREF outside a frame (IDLE/ARMED) is ignored.
- If the VSYNC rise and the HREF fall occur on the same cycle, the frame end takes priority. A pending Y1 write still issues before frame_done.

Test Plan:
- Reset mid-line during CAPTURE, with wr_en toggling -> the next cycle shows all outputs 0; no writes until the next VSYNC fall.
- scale=0, mode=0, one 4x2 frame (H_ACTIVE=4, V_ACTIVE=2), bytes Cb=80, Y=10,11,..., Cr=80 -> writes at addr 0..7 with data 10..17 in order; frame_done pulses once, 1 cycle after VSYNC rises.
- scale=1, H_ACTIVE=8, 4 lines -> only even x on rows 0 and 2 are written. Addr 0..3 come from row 0 (x=0,2,4,6) and addr 4..7 from row 2. No writes on rows 1 and 3.
- mode=1, pair Cb=100, Cr=100, Y0=50, Y1=60 -> two writes of 8'hFF. Pair Cb=130, Cr=100 -> writes 50, 60.
- Line of 10 pixels with H_ACTIVE=8 -> 8 writes, ovf=1 held until the next frame start. Line ending at phase 1 -> no write for that partial pair.
- enable dropped mid-frame -> the frame completes with frame_done pulsed, busy=0, state IDLE; the following VSYNC fall produces no writes.
